mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit; consumes the mem_* fields produced by the EXE/MEM pipeline register.
//  Issues one data-bus transaction per memory instruction over a req/ack handshake, then sign/zero-extends load data.
//  Raises stall_req toward pipeline control while a transaction is in flight; honours flush.
//  Sits between the EXE/MEM register and the MEM/WB register, as the bus initiator toward data memory.
// PARAMETERS
//  ADDR_W   32  data-bus address width
//  DATA_W   32  data-bus data width (fixed 32; other values unsupported)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  flush        in   1   synchronous pipeline flush (exception/eret)
//  mem_aluop    in   8   op: LB 8'h90 LBU 8'h91 LH 8'h92 LHU 8'h93 LW 8'h94 SB 8'h98 SH 8'h99 SW 8'h9A; all else (incl. 8'h00, 8'h11 bubble) = no access
//  mem_wd       in   32  effective address (computed in EXE)
//  mem_din      in   32  store data
//  mem_exccode  in   5   upstream exception code; 5'h10 = none
//  dbus_req     out  1   request valid; held until dbus_ack
//  dbus_we      out  1   1 = store
//  dbus_be      out  4   byte enables, little-endian lanes
//  dbus_addr    out  32  word address {addr[31:2],2'b00}
//  dbus_wdata   out  32  lane-replicated store data
//  dbus_ack     in   1   transaction complete; dbus_rdata valid same cycle for loads
//  dbus_rdata   in   32  read word
//  stall_req    out  1   freeze MEM and earlier stages; bubble into MEM/WB
//  lsu_rdata    out  32  extended load result (registered)
//  lsu_valid    out  1   access finished this cycle; lsu_rdata valid for loads
//  lsu_exccode  out  5   exception code forwarded to MEM/WB
//  lsu_badvaddr out  32  faulting address (valid when lsu_exccode is AdEL/AdES)
// BEHAVIOUR
//  Reset: state IDLE; dbus_req/we 0, dbus_be 0, dbus_addr 0, dbus_wdata 0, lsu_rdata 0; stall_req 0, lsu_valid 0, lsu_exccode 5'h10, lsu_badvaddr 0.
//  access = memory op AND mem_exccode==5'h10 AND no alignment fault.
//  FSM IDLE -> BUSY -> DONE -> IDLE; plus ABORT.
//   IDLE : access -> register dbus_* , dbus_req<=1, go BUSY. stall_req = access (comb).
//   BUSY : stall_req=1; dbus_* stable. On dbus_ack: dbus_req<=0, lsu_rdata<=extended rdata (loads), go DONE.
//   DONE : stall_req=0, lsu_valid=1; pipeline advances this edge; next state IDLE.
//   ABORT: dbus_req held until dbus_ack, result discarded, lsu_valid=0; stall_req = access; on ack -> IDLE.
//  Minimum latency: ack in the first BUSY cycle -> result in the 3rd cycle after op arrives (IDLE, BUSY, DONE).
//  flush: IDLE/DONE -> IDLE, no issue this cycle; BUSY w/o ack -> ABORT; BUSY with ack -> IDLE, data discarded.
//   flush has priority over a new access in the same cycle.
//  Lanes: byte be=1<<addr[1:0]; half be=addr[1]?4'b1100:4'b0011; word be=4'b1111.
//   SB wdata={4{din[7:0]}}, SH {2{din[15:0]}}, SW din.
//  Load extend: select byte/half by addr[1:0]/addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
//  lsu_exccode combinational: mem_exccode if !=5'h10, else alignment code, else 5'h10.
//  dbus_ack outside BUSY/ABORT is ignored.
// CONFIGURATION
//  MEM_ALIGN_EXC_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 -> no bus access, no stall;
//   lsu_exccode=5'h04 (AdEL, loads) / 5'h05 (AdES, stores); lsu_badvaddr=mem_wd.
//  Undefined: no alignment check; half ignores addr[0], word ignores addr[1:0]; lsu_badvaddr tied 0.
// STRUCTURE
//  Shared package mips_defs_pkg: aluop codes above, EXC_NONE 5'h10, EXC_ADEL 5'h04, EXC_ADES 5'h05, LSU state encoding.
//  Sub-module lsu_load_ext: combinational lane select + sign/zero extension (op, addr[1:0], rdata -> 32b).
// TESTING
//  LW addr 0x100, rdata 0xDEADBEEF, ack 2 cycles after req -> be 4'hF, addr 0x100, lsu_rdata 0xDEADBEEF, stall_req high 3 cycles.
//  LB addr 0x103, rdata 0x80FF_0000 -> be 4'b1000, lsu_rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x202, din 0x1234ABCD -> we 1, be 4'b1100, wdata 0xABCDABCD, lsu_valid one cycle after ack.
//  MEM_ALIGN_EXC_EN: LW addr 0x101 -> dbus_req stays 0, stall_req 0, lsu_exccode 5'h04, lsu_badvaddr 0x101.
//  flush in first BUSY cycle, ack 3 cycles later -> dbus_req held to ack, lsu_valid never asserts, FSM IDLE after ack.
//  rst_n low mid-BUSY -> all outputs at reset values immediately; late ack ignored.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: memory aluop codes, exception codes, LSU state encoding.
// Access-size decode helpers used by the LSU and its load-extension datapath.
package mips_defs_pkg;

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;
    localparam logic [7:0] OP_NOP = 8'h00;

    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [1:0] LSU_IDLE  = 2'd0;
    localparam logic [1:0] LSU_BUSY  = 2'd1;
    localparam logic [1:0] LSU_DONE  = 2'd2;
    localparam logic [1:0] LSU_ABORT = 2'd3;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } lsu_size_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic lsu_size_e op_size(input logic [7:0] op);
        lsu_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            OP_LW, OP_SW:         sz = SZ_WORD;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/acknowledge bundle between the LSU (master) and data memory (slave).
// Request and write fields are held by the master until dbus_ack; read data is valid with dbus_ack.
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  dbus_req;
    logic                  dbus_we;
    logic [DATA_W/8-1:0]   dbus_be;
    logic [ADDR_W-1:0]     dbus_addr;
    logic [DATA_W-1:0]     dbus_wdata;
    logic                  dbus_ack;
    logic [DATA_W-1:0]     dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension; purely combinational, no backpressure.
// Halfword lane is chosen by offset bit 1 only, so a misaligned half reads its aligned half.
module lsu_load_ext
    import mips_defs_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-bus transaction per memory op, min 3 cycles op-to-result (IDLE, BUSY, DONE).
// Holds stall_req while the bus is outstanding; alignment exceptions enabled by MEM_ALIGN_EXC_EN.
module mem_lsu
    import mips_defs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [7:0]         mem_aluop,
    input  logic [ADDR_W-1:0]  mem_wd,
    input  logic [DATA_W-1:0]  mem_din,
    input  logic [4:0]         mem_exccode,
    mem_lsu_if.master          dbus,
    output logic               stall_req,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic               lsu_valid,
    output logic [4:0]         lsu_exccode,
    output logic [ADDR_W-1:0]  lsu_badvaddr
);

    logic [1:0]        r_state;
    logic              r_req;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [7:0]        r_op;
    logic [1:0]        r_off;
    logic [31:0]       r_rdata;

    lsu_size_e   w_size;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_access;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    assign w_size     = op_size(mem_aluop);
    assign w_is_load  = is_load(mem_aluop);
    assign w_is_store = is_store(mem_aluop);

`ifdef MEM_ALIGN_EXC_EN
    assign w_misalign   = ((w_size == SZ_HALF) && mem_wd[0]) ||
                          ((w_size == SZ_WORD) && (mem_wd[1:0] != 2'b00));
    assign lsu_badvaddr = w_misalign ? mem_wd : '0;
`else
    assign w_misalign   = 1'b0;
    assign lsu_badvaddr = '0;
`endif

    // Reset gates the request so a held op cannot raise stall while rst_n is low.
    assign w_access = rst_n && (w_is_load || w_is_store) &&
                      (mem_exccode == EXC_NONE) && !w_misalign;

    always_comb begin
        lsu_exccode = EXC_NONE;
        if (mem_exccode != EXC_NONE)
            lsu_exccode = mem_exccode;
        else if (w_misalign)
            lsu_exccode = w_is_load ? EXC_ADEL : EXC_ADES;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = mem_din[31:0];
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << mem_wd[1:0];
                w_wdata = {4{mem_din[7:0]}};
            end
            SZ_HALF: begin
                w_be    = mem_wd[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_din[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = mem_din[31:0];
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = mem_din[31:0];
            end
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            LSU_IDLE:  stall_req = w_access;
            LSU_BUSY:  stall_req = 1'b1;
            LSU_DONE:  stall_req = 1'b0;
            default:   stall_req = w_access;
        endcase
    end

    assign lsu_valid = (r_state == LSU_DONE);

    lsu_load_ext u_load_ext (
        .i_op    (r_op),
        .i_off   (r_off),
        .i_rdata (dbus.dbus_rdata[31:0]),
        .o_data  (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_NOP;
            r_off   <= 2'b00;
            r_rdata <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (!flush && w_access) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_be    <= w_be;
                        r_addr  <= {mem_wd[ADDR_W-1:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_op    <= mem_aluop;
                        r_off   <= mem_wd[1:0];
                        r_state <= LSU_BUSY;
                    end
                end
                LSU_BUSY: begin
                    if (dbus.dbus_ack) begin
                        r_req <= 1'b0;
                        if (flush) begin
                            r_state <= LSU_IDLE;
                        end else begin
                            if (is_load(r_op))
                                r_rdata <= w_ext;
                            r_state <= LSU_DONE;
                        end
                    end else if (flush) begin
                        r_state <= LSU_ABORT;
                    end
                end
                LSU_DONE: begin
                    r_state <= LSU_IDLE;
                end
                default: begin
                    // Flushed mid-transaction: the bus must still see its ack, but the data is dropped.
                    if (dbus.dbus_ack) begin
                        r_req   <= 1'b0;
                        r_state <= LSU_IDLE;
                    end
                end
            endcase
        end
    end

    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_be    = r_be;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_wdata = r_wdata;
    assign lsu_rdata       = r_rdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, lane handling, exceptions, flush and mid-transaction reset.
module tb_mem_lsu;
    import mips_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  mem_aluop = OP_NOP;
    logic [31:0] mem_wd = '0;
    logic [31:0] mem_din = '0;
    logic [4:0]  mem_exccode = EXC_NONE;
    logic        stall_req;
    logic [31:0] lsu_rdata;
    logic        lsu_valid;
    logic [4:0]  lsu_exccode;
    logic [31:0] lsu_badvaddr;

    int n_chk  = 0;
    int n_fail = 0;

    int          o_stall;
    int          o_valid_cnt;
    logic        o_valid_done;
    logic        o_req;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [31:0] o_res;

    mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .mem_aluop    (mem_aluop),
        .mem_wd       (mem_wd),
        .mem_din      (mem_din),
        .mem_exccode  (mem_exccode),
        .dbus         (bus),
        .stall_req    (stall_req),
        .lsu_rdata    (lsu_rdata),
        .lsu_valid    (lsu_valid),
        .lsu_exccode  (lsu_exccode),
        .lsu_badvaddr (lsu_badvaddr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Drives one memory op, acks it in BUSY cycle 'dly', and records what the bus and pipeline saw.
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                             input logic [31:0] rdata, input int dly);
        o_stall = 0; o_valid_cnt = 0; o_valid_done = 1'b0;
        @(negedge clk);
        mem_aluop = op; mem_wd = addr; mem_din = din; mem_exccode = EXC_NONE;
        #1;
        if (stall_req) o_stall++;
        @(posedge clk); #1;
        o_req = bus.dbus_req; o_we = bus.dbus_we; o_be = bus.dbus_be;
        o_addr = bus.dbus_addr; o_wdata = bus.dbus_wdata;
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            if (stall_req) o_stall++;
            if (lsu_valid) o_valid_cnt++;
            if (k == dly) begin
                bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata;
            end
            @(posedge clk); #1;
            bus.dbus_ack = 1'b0;
        end
        @(negedge clk);
        if (stall_req) o_stall++;
        if (lsu_valid) begin o_valid_cnt++; o_valid_done = 1'b1; end
        o_res = lsu_rdata;
        mem_aluop = OP_NOP;
        @(posedge clk);
        @(negedge clk);
        if (stall_req) o_stall++;
        if (lsu_valid) o_valid_cnt++;
    endtask

    task automatic test_reset;
        bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
        #2;
        n_chk++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.dbus_req); end
        n_chk++; if (bus.dbus_be !== 4'h0) begin n_fail++; $display("FAIL rst_be got %h exp 0", bus.dbus_be); end
        n_chk++; if (lsu_exccode !== EXC_NONE) begin n_fail++; $display("FAIL rst_exc got %h exp 10", lsu_exccode); end
        n_chk++; if ({stall_req, lsu_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_stall_valid got %b exp 00", {stall_req, lsu_valid}); end
        n_chk++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", lsu_rdata); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_lw;
        do_access(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        n_chk++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL lw_req got %b exp 1", o_req); end
        n_chk++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL lw_be got %h exp f", o_be); end
        n_chk++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h exp 100", o_addr); end
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL lw_we got %b exp 0", o_we); end
        n_chk++; if (o_res !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h exp deadbeef", o_res); end
        n_chk++; if (o_stall !== 3) begin n_fail++; $display("FAIL lw_stall_cycles got %0d exp 3", o_stall); end
        n_chk++; if (o_valid_cnt !== 1 || o_valid_done !== 1'b1) begin n_fail++; $display("FAIL lw_valid got cnt %0d done %b exp 1 1", o_valid_cnt, o_valid_done); end
    endtask

    task automatic test_byte_loads;
        do_access(OP_LB, 32'h103, 32'h0, 32'h80FF_0000, 1);
        n_chk++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b exp 1000", o_be); end
        n_chk++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr got %h exp 100", o_addr); end
        n_chk++; if (o_res !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h exp ffffff80", o_res); end
        n_chk++; if (o_stall !== 2) begin n_fail++; $display("FAIL lb_stall_cycles got %0d exp 2", o_stall); end
        do_access(OP_LBU, 32'h103, 32'h0, 32'h80FF_0000, 1);
        n_chk++; if (o_res !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got %h exp 00000080", o_res); end
    endtask

    task automatic test_half_loads;
        do_access(OP_LH, 32'h202, 32'h0, 32'h8001_1234, 1);
        n_chk++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got %b exp 1100", o_be); end
        n_chk++; if (o_res !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata got %h exp ffff8001", o_res); end
        do_access(OP_LHU, 32'h200, 32'h0, 32'h1234_F00F, 1);
        n_chk++; if (o_be !== 4'b0011) begin n_fail++; $display("FAIL lhu_be got %b exp 0011", o_be); end
        n_chk++; if (o_res !== 32'h0000F00F) begin n_fail++; $display("FAIL lhu_rdata got %h exp 0000f00f", o_res); end
    endtask

    task automatic test_stores;
        do_access(OP_SH, 32'h202, 32'h1234ABCD, 32'h5555_5555, 3);
        n_chk++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL sh_we got %b exp 1", o_we); end
        n_chk++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b exp 1100", o_be); end
        n_chk++; if (o_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", o_wdata); end
        n_chk++; if (o_valid_done !== 1'b1 || o_valid_cnt !== 1) begin n_fail++; $display("FAIL sh_valid got done %b cnt %0d exp 1 1", o_valid_done, o_valid_cnt); end
        n_chk++; if (o_stall !== 4) begin n_fail++; $display("FAIL sh_stall_cycles got %0d exp 4", o_stall); end
        n_chk++; if (o_res !== 32'h0000F00F) begin n_fail++; $display("FAIL sh_keeps_rdata got %h exp 0000f00f", o_res); end
        do_access(OP_SB, 32'h101, 32'h000000A5, 32'h0, 1);
        n_chk++; if (o_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be got %b exp 0010", o_be); end
        n_chk++; if (o_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_wdata); end
        do_access(OP_SW, 32'h30C, 32'h0BADF00D, 32'h0, 1);
        n_chk++; if (o_wdata !== 32'h0BADF00D || o_be !== 4'hF) begin n_fail++; $display("FAIL sw_wdata_be got %h/%h exp 0badf00d/f", o_wdata, o_be); end
    endtask

    task automatic test_misalign;
`ifdef MEM_ALIGN_EXC_EN
        @(negedge clk);
        mem_aluop = OP_LW; mem_wd = 32'h101; mem_exccode = EXC_NONE;
        #1;
        n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL adel_stall got %b exp 0", stall_req); end
        n_chk++; if (lsu_exccode !== EXC_ADEL) begin n_fail++; $display("FAIL adel_code got %h exp 04", lsu_exccode); end
        n_chk++; if (lsu_badvaddr !== 32'h101) begin n_fail++; $display("FAIL adel_badvaddr got %h exp 101", lsu_badvaddr); end
        @(posedge clk); #1;
        n_chk++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL adel_req got %b exp 0", bus.dbus_req); end
        @(negedge clk);
        mem_aluop = OP_SH; mem_wd = 32'h203;
        #1;
        n_chk++; if (lsu_exccode !== EXC_ADES) begin n_fail++; $display("FAIL ades_code got %h exp 05", lsu_exccode); end
        @(posedge clk); #1;
        n_chk++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL ades_req got %b exp 0", bus.dbus_req); end
        mem_aluop = OP_NOP;
`else
        do_access(OP_LW, 32'h101, 32'h0, 32'hCAFEF00D, 1);
        n_chk++; if (o_addr !== 32'h100 || o_be !== 4'hF) begin n_fail++; $display("FAIL lw_unaligned_bus got %h/%h exp 100/f", o_addr, o_be); end
        n_chk++; if (o_res !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw_unaligned_rdata got %h exp cafef00d", o_res); end
        @(negedge clk);
        mem_aluop = OP_LH; mem_wd = 32'h203; mem_exccode = EXC_NONE;
        #1;
        n_chk++; if (lsu_exccode !== EXC_NONE || lsu_badvaddr !== 32'h0) begin n_fail++; $display("FAIL noalign_exc got %h/%h exp 10/0", lsu_exccode, lsu_badvaddr); end
        n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL noalign_stall got %b exp 1", stall_req); end
        mem_aluop = OP_NOP;
        #1;
`endif
    endtask

    task automatic test_exc_and_bubble;
        @(negedge clk);
        mem_aluop = OP_LW; mem_wd = 32'h100; mem_exccode = 5'h0C;
        #1;
        n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL exc_stall got %b exp 0", stall_req); end
        n_chk++; if (lsu_exccode !== 5'h0C) begin n_fail++; $display("FAIL exc_fwd got %h exp 0c", lsu_exccode); end
        @(posedge clk); #1;
        n_chk++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL exc_req got %b exp 0", bus.dbus_req); end
        @(negedge clk);
        mem_aluop = 8'h11; mem_exccode = EXC_NONE;
        #1;
        n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL bubble_stall got %b exp 0", stall_req); end
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.dbus_ack = 1'b0;
        @(negedge clk);
        n_chk++; if (lsu_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack got valid %b req %b exp 0 0", lsu_valid, bus.dbus_req); end
        n_chk++; if (lsu_rdata !== 32'hCAFEF00D && lsu_rdata !== 32'h0000F00F) begin n_fail++; $display("FAIL idle_ack_rdata got %h exp unchanged", lsu_rdata); end
        mem_aluop = OP_NOP;
    endtask

    task automatic test_flush_busy;
        logic [31:0] prev;
        int vcnt = 0;
        prev = lsu_rdata;
        @(negedge clk);
        mem_aluop = OP_LW; mem_wd = 32'h300; mem_exccode = EXC_NONE;
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1'b1; mem_aluop = OP_NOP;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (lsu_valid) vcnt++;
            n_chk++; if (bus.dbus_req !== 1'b1 || stall_req !== 1'b0) begin n_fail++; $display("FAIL abort_hold_%0d got req %b stall %b exp 1 0", k, bus.dbus_req, stall_req); end
            if (k == 3) begin bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h1111_1111; end
            @(posedge clk); #1;
            bus.dbus_ack = 1'b0;
        end
        @(negedge clk);
        if (lsu_valid) vcnt++;
        n_chk++; if (vcnt !== 0) begin n_fail++; $display("FAIL abort_valid got %0d cycles exp 0", vcnt); end
        n_chk++; if (bus.dbus_req !== 1'b0 || dut.r_state !== LSU_IDLE) begin n_fail++; $display("FAIL abort_idle got req %b state %0d exp 0 0", bus.dbus_req, dut.r_state); end
        n_chk++; if (lsu_rdata !== prev) begin n_fail++; $display("FAIL abort_rdata got %h exp %h", lsu_rdata, prev); end
    endtask

    task automatic test_flush_with_ack;
        logic [31:0] prev;
        prev = lsu_rdata;
        @(negedge clk);
        mem_aluop = OP_LW; mem_wd = 32'h304; mem_exccode = EXC_NONE;
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1'b1; mem_aluop = OP_NOP;
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h2222_2222;
        @(posedge clk); #1;
        flush = 1'b0; bus.dbus_ack = 1'b0;
        @(negedge clk);
        n_chk++; if (lsu_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL flush_ack got valid %b req %b exp 0 0", lsu_valid, bus.dbus_req); end
        n_chk++; if (lsu_rdata !== prev || dut.r_state !== LSU_IDLE) begin n_fail++; $display("FAIL flush_ack_drop got %h state %0d exp %h 0", lsu_rdata, dut.r_state, prev); end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        mem_aluop = OP_SW; mem_wd = 32'h404; mem_din = 32'h1357_9BDF; mem_exccode = EXC_NONE;
        @(posedge clk); #1;
        n_chk++; if (bus.dbus_req !== 1'b1 || lsu_rdata === 32'h0) begin n_fail++; $display("FAIL prerst_busy got req %b rdata %h exp 1 nonzero", bus.dbus_req, lsu_rdata); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.dbus_req, bus.dbus_we, bus.dbus_be} !== 6'b0) begin n_fail++; $display("FAIL midrst_ctl got %b exp 000000", {bus.dbus_req, bus.dbus_we, bus.dbus_be}); end
        n_chk++; if (bus.dbus_addr !== 32'h0 || bus.dbus_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_addr_wdata got %h/%h exp 0/0", bus.dbus_addr, bus.dbus_wdata); end
        n_chk++; if ({stall_req, lsu_valid} !== 2'b00 || lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_out got %b/%h exp 00/0", {stall_req, lsu_valid}, lsu_rdata); end
        @(negedge clk);
        rst_n = 1'b1; mem_aluop = OP_NOP;
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h3333_3333;
        @(posedge clk); #1;
        bus.dbus_ack = 1'b0;
        @(negedge clk);
        n_chk++; if (lsu_valid !== 1'b0 || bus.dbus_req !== 1'b0 || lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL late_ack got valid %b req %b rdata %h exp 0 0 0", lsu_valid, bus.dbus_req, lsu_rdata); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_stores();
        test_misalign();
        test_exc_and_bubble();
        test_flush_busy();
        test_flush_with_ack();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
